// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 11-bit UART serialiser (start, D7..D0, spare/parity, stop).
// Define UART_TX_PARITY_EN to carry even parity in the spare slot; otherwise the slot is a second stop bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] data_in,
  output logic       Tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic [BW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic par, head_par, push, pop, baud_last;
  always_comb begin
    push = wr && !full;
    baud_last = baud == BW'(CLKS_PER_BIT - 1);
    pop = !empty && (state == IDLE || (state == STOP && baud_last));
    count_nxt = count + CW'(push) - CW'(pop);
`ifdef UART_TX_PARITY_EN
    head_par = ^mem[rptr];
`else
    head_par = 1'b1;
`endif
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= data_in;
  // A pop always starts a frame, whether from IDLE or back-to-back from the last STOP cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      Tx <= 1'b1;
      busy <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
      baud <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (wr && full) overflow <= 1'b1;
      count <= count_nxt;
      full <= count_nxt == CW'(DEPTH);
      empty <= count_nxt == '0;
      if (pop) begin
        sh <= mem[rptr];
        par <= head_par;
        Tx <= 1'b0;
        busy <= 1'b1;
        baud <= '0;
        state <= START;
      end else if (state != IDLE) begin
        baud <= baud_last ? '0 : baud + 1'b1;
        if (baud_last)
          case (state)
            START: begin
              state <= DATA;
              Tx <= sh[7];
              bit_cnt <= '0;
            end
            DATA: begin
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
                Tx <= par;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                sh <= sh << 1;
                Tx <= sh[6];
              end
            end
            PARITY: begin
              state <= STOP;
              Tx <= 1'b1;
            end
            default: begin
              state <= IDLE;
              busy <= 1'b0;
              Tx <= 1'b1;
            end
          endcase
      end
    end
  end
endmodule
